// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU control stage: ALUOp classes, Funct codes,
// ALUControl codes and the multiply/divide sequencer state type.
package alu_ctrl_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_ILL   = 3'b111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_NOR  = 4'b0100;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLL  = 4'b1000;
  localparam logic [3:0] CTL_SRL  = 4'b1001;
  localparam logic [3:0] CTL_SRA  = 4'b1010;
  localparam logic [3:0] CTL_MULT = 4'b1100;
  localparam logic [3:0] CTL_DIV  = 4'b1101;
  localparam logic [3:0] CTL_MFHI = 4'b1110;
  localparam logic [3:0] CTL_MFLO = 4'b1111;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // All HI/LO-touching codes (MULT, DIV, MFHI, MFLO) share the 11xx prefix.
  function automatic logic ctl_is_hilo(input logic [3:0] ctl);
    return ctl[3] & ctl[2];
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide latency sequencer: tracks an in-flight HI/LO operation with a
// 6-bit down-counter and pulses hilo_we in its final cycle.
module md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic hilo_we
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  md_state_t  state;
  md_state_t  state_nx;
  logic [5:0] count;
  logic [5:0] count_nx;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      count <= 6'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Next-state logic: load the latency on start, count down, leave at zero.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nx = MD_BUSY;
          count_nx = is_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          count_nx = 6'd0;
        end
      end
      MD_BUSY: begin
        if (count == 6'd0) begin
          state_nx = MD_IDLE;
        end else begin
          count_nx = count - 6'd1;
        end
      end
      default: begin
        state_nx = MD_IDLE;
        count_nx = 6'd0;
      end
    endcase
  end

  assign busy    = (state == MD_BUSY);
  assign hilo_we = (state == MD_BUSY) && (count == 6'd0);

endmodule

// File: rtl/alu_control_seq.sv
// ID/EX ALU control: decodes ALUOp/Funct into a registered ALUControl word.
// Macro ALUCTL_MULDIV_EN builds the HI/LO multiply/divide sequencer and stall logic.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 2,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         Funct,
  input  logic               stall_in,
  input  logic               flush,
  output logic               ex_valid,
  output logic [CTRL_W-1:0]  ALUControl,
  output logic               ex_unsigned,
  output logic               illegal,
  output logic               md_busy,
  output logic               hilo_we,
  output logic               stall_req
);

  logic [2:0] op_ext;
  logic [3:0] dec_ctrl;
  logic       dec_unsigned;
  logic       dec_illegal;
  logic       advance;

  // A 2-bit ALUOp zero-extends, so the immediate-logic classes are unreachable.
  assign op_ext = 3'(ALUOp);

  // ALUOp/Funct decode.
  always_comb begin
    dec_ctrl     = CTL_ADD;
    dec_unsigned = 1'b0;
    dec_illegal  = 1'b0;
    case (op_ext)
      ALUOP_ADD: dec_ctrl = CTL_ADD;
      ALUOP_SUB: dec_ctrl = CTL_SUB;
      ALUOP_SLT: dec_ctrl = CTL_SLT;
      ALUOP_AND: dec_ctrl = CTL_AND;
      ALUOP_OR:  dec_ctrl = CTL_OR;
      ALUOP_XOR: dec_ctrl = CTL_XOR;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD, FN_ADDU: begin
            dec_ctrl     = CTL_ADD;
            dec_unsigned = Funct[0];
          end
          FN_SUB, FN_SUBU: begin
            dec_ctrl     = CTL_SUB;
            dec_unsigned = Funct[0];
          end
          FN_SLT, FN_SLTU: begin
            dec_ctrl     = CTL_SLT;
            dec_unsigned = Funct[0];
          end
          FN_AND: dec_ctrl = CTL_AND;
          FN_OR:  dec_ctrl = CTL_OR;
          FN_XOR: dec_ctrl = CTL_XOR;
          FN_NOR: dec_ctrl = CTL_NOR;
          FN_SLL: dec_ctrl = CTL_SLL;
          FN_SRL: dec_ctrl = CTL_SRL;
          FN_SRA: dec_ctrl = CTL_SRA;
`ifdef ALUCTL_MULDIV_EN
          FN_MULT, FN_MULTU: begin
            dec_ctrl     = CTL_MULT;
            dec_unsigned = Funct[0];
          end
          FN_DIV, FN_DIVU: begin
            dec_ctrl     = CTL_DIV;
            dec_unsigned = Funct[0];
          end
          FN_MFHI: dec_ctrl = CTL_MFHI;
          FN_MFLO: dec_ctrl = CTL_MFLO;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef ALUCTL_MULDIV_EN
  logic md_start;

  // HI/LO users wait in ID until the sequencer has fully retired, including its hilo_we cycle.
  assign stall_req = md_busy & id_valid & ctl_is_hilo(dec_ctrl);
  assign md_start  = advance & id_valid & ~flush & ctl_is_hilo(dec_ctrl) & ~dec_ctrl[1];

  md_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .is_div  (dec_ctrl[0]),
    .busy    (md_busy),
    .hilo_we (hilo_we)
  );
`else
  assign md_busy   = 1'b0;
  assign hilo_we   = 1'b0;
  assign stall_req = 1'b0;
`endif

  assign advance = ~stall_in & ~stall_req;

  // ID/EX pipeline register; a flush only clears the valid bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ALUControl  <= CTRL_W'(CTL_ADD);
      ex_unsigned <= 1'b0;
      illegal     <= 1'b0;
    end else if (advance) begin
      ex_valid    <= id_valid & ~flush;
      ALUControl  <= CTRL_W'(dec_ctrl);
      ex_unsigned <= dec_unsigned;
      illegal     <= dec_illegal;
    end else begin
      ex_valid    <= ex_valid;
      ALUControl  <= ALUControl;
      ex_unsigned <= ex_unsigned;
      illegal     <= illegal;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus randomized
// traffic, all compared against a cycle-level reference model of the decode rules.
module tb_alu_control_seq;

`ifdef ALUCTL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic       clk = 1'b0;
  logic       reset_n, id_valid, stall_in, flush;
  logic [2:0] ALUOp;
  logic [5:0] Funct;
  logic       ex_valid, ex_unsigned, illegal, md_busy, hilo_we, stall_req;
  logic [3:0] ALUControl;

  alu_control_seq #(.ALUOP_W(3), .CTRL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .ALUOp(ALUOp), .Funct(Funct),
    .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ALUControl(ALUControl),
    .ex_unsigned(ex_unsigned), .illegal(illegal), .md_busy(md_busy), .hilo_we(hilo_we),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Legal R-type functions and the ALU operation each one names (index >= 13: HI/LO family).
  logic [5:0] fn_tab [19] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                              6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                              6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011001,
                              6'b011010, 6'b011011, 6'b010000, 6'b010010};
  logic [3:0] op_tab [19] = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd7, 4'd7,
                              4'd8, 4'd9, 4'd10, 4'd12, 4'd12, 4'd13, 4'd13, 4'd14, 4'd15};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected EX register contents and remaining HI/LO busy cycles.
  logic       m_valid, m_uns, m_ill;
  logic [3:0] m_ctrl;
  int         rem;
  int         busy_cnt, hilo_cnt, hilo_at, stall_cnt;
  logic       last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_decode(input logic [2:0] op, input logic [5:0] fn,
                                       output logic [3:0] code, output logic uns, output logic ill);
    int idx = -1;
    code = 4'd2;
    uns  = 1'b0;
    ill  = 1'b0;
    case (op)
      3'd0: code = 4'd2;
      3'd1: code = 4'd6;
      3'd3: code = 4'd7;
      3'd4: code = 4'd0;
      3'd5: code = 4'd1;
      3'd6: code = 4'd3;
      3'd7: ill = 1'b1;
      default: begin
        for (int i = 0; i < 19; i++) if (fn_tab[i] == fn) idx = i;
        if (idx < 0 || (idx >= 13 && !MD_EN)) ill = 1'b1;
        else begin
          code = op_tab[idx];
          uns  = fn[0] && (code inside {4'd2, 4'd6, 4'd7, 4'd12, 4'd13});
        end
      end
    endcase
  endfunction

  function automatic bit hilo_family(input logic [5:0] fn);
    return fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010};
  endfunction

  task automatic step(input logic rn, input logic v, input logic [2:0] op, input logic [5:0] fn,
                      input logic si, input logic fl);
    logic [3:0] c;
    logic u, il, st, adv;
    reset_n = rn; id_valid = v; ALUOp = op; Funct = fn; stall_in = si; flush = fl;
    @(negedge clk);
    st = MD_EN && rem > 0 && v && op == 3'd2 && hilo_family(fn);
    check("ex_valid", 32'(ex_valid), 32'(m_valid));
    check("alu_control", 32'(ALUControl), 32'(m_ctrl));
    check("ex_unsigned", 32'(ex_unsigned), 32'(m_uns));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("md_busy", 32'(md_busy), 32'(rem > 0));
    check("hilo_we", 32'(hilo_we), 32'(rem == 1));
    check("stall_req", 32'(stall_req), 32'(st));
    busy_cnt += int'(md_busy);
    hilo_cnt += int'(hilo_we);
    stall_cnt += int'(stall_req);
    if (hilo_we) hilo_at = busy_cnt;
    last_stall = st;
    model_decode(op, fn, c, u, il);
    if (!rn) begin
      m_valid = 1'b0; m_ctrl = 4'd2; m_uns = 1'b0; m_ill = 1'b0; rem = 0;
    end else begin
      adv = !si && !st;
      rem = (rem > 0) ? rem - 1 : 0;
      if (adv && v && !fl && c == 4'd12) rem = MUL_N;
      if (adv && v && !fl && c == 4'd13) rem = DIV_N;
      if (adv) begin
        m_valid = v && !fl; m_ctrl = c; m_uns = u; m_ill = il;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; hilo_cnt = 0; hilo_at = 0; stall_cnt = 0;
  endtask

  initial begin
    m_valid = 1'b0; m_ctrl = 4'd2; m_uns = 1'b0; m_ill = 1'b0; rem = 0;
    clear_counts();
    reset_n = 1'b0; id_valid = 1'b1; ALUOp = 3'd1; Funct = 6'd0; stall_in = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_ctrl", 32'(ALUControl), 32'd2);
    step(1'b0, 1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    check("release_ctrl", 32'(ALUControl), 32'd6);
    check("release_valid", 32'(ex_valid), 32'd1);

    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b1, 3'd2, fn_tab[i], 1'b0, 1'b0);
      check("sweep_ctrl", 32'(ALUControl), 32'(op_tab[i]));
    end
    step(1'b1, 1'b1, 3'd2, 6'b100011, 1'b0, 1'b0);
    check("subu_unsigned", 32'(ex_unsigned), 32'd1);
    step(1'b1, 1'b1, 3'd2, 6'b111111, 1'b0, 1'b0);
    check("bad_fn_illegal", 32'(illegal), 32'd1);
    check("bad_fn_ctrl", 32'(ALUControl), 32'd2);
    step(1'b1, 1'b1, 3'd6, 6'd0, 1'b0, 1'b0);
    check("imm_xor", 32'(ALUControl), 32'd3);

    clear_counts();
    step(1'b1, 1'b1, 3'd2, 6'b011000, 1'b0, 1'b0);
    check("mult_illegal", 32'(illegal), 32'(!MD_EN));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    check("mult_busy_cycles", 32'(busy_cnt), MD_EN ? 32'd4 : 32'd0);
    check("mult_hilo_count", 32'(hilo_cnt), MD_EN ? 32'd1 : 32'd0);
    check("mult_hilo_at", 32'(hilo_at), MD_EN ? 32'd4 : 32'd0);

    clear_counts();
    step(1'b1, 1'b1, 3'd2, 6'b011010, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 3'd2, 6'b010010, 1'b0, 1'b0);
      if (!last_stall) break;
    end
    check("div_stall_cycles", 32'(stall_cnt), MD_EN ? 32'd32 : 32'd0);
    check("mflo_ctrl", 32'(ALUControl), MD_EN ? 32'd15 : 32'd2);

    step(1'b1, 1'b1, 3'd2, 6'b011011, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 6'b100000, 1'b0, 1'b0);
    check("add_in_busy_ctrl", 32'(ALUControl), 32'd2);
    check("add_in_busy_busy", 32'(md_busy), 32'(MD_EN));
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 3'd2, 6'b011000, 1'b0, 1'b1);
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_busy", 32'(md_busy), 32'd0);
    step(1'b1, 1'b1, 3'd1, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'd3, 6'd0, 1'b1, 1'b0);
      check("stall_in_hold", 32'(ALUControl), 32'd6);
    end

    step(1'b1, 1'b1, 3'd2, 6'b011001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    check("reset_mid_busy", 32'(md_busy), 32'd0);
    clear_counts();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    check("reset_mid_hilo", 32'(hilo_cnt), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [5:0] fn;
      logic [2:0] op;
      fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 18)] : 6'($urandom);
      op = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 7) != 0), op, fn,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
